// File: rtl/mouse_paddle_ctrl.sv
// -----------------------------------------------------------------------------
// mouse_paddle_ctrl
//
// Sits behind the PS/2 mouse receiver and turns its button levels into a
// rate-limited, clamped vertical paddle position for the ball game.
//
// The receiver's outputs live in the filtered-PS/2-clock domain, so every input
// is passed through a two-flop synchroniser into clk_12MHz. A rising edge of the
// synchronised packet-valid level is one packet event. Each event selects the
// movement direction: left button = up (has priority), right button = down,
// neither = stop. A free-running tick divider paces the movement. A hold
// counter stops the paddle when no packet has arrived for HOLD_TICKS ticks.
//
// Ports
//   clk_12MHz     in   1   system clock
//   reset         in   1   asynchronous, active-low reset
//   i_upr         in   1   left-button level from receiver (async domain)
//   i_downr       in   1   right-button level from receiver (async domain)
//   i_valid       in   1   packet-valid level from receiver (async domain)
//   o_pos_y       out  10  paddle top coordinate
//   o_move_up     out  1   FSM is in UP
//   o_move_down   out  1   FSM is in DOWN
//   o_at_top      out  1   o_pos_y == PADDLE_MIN
//   o_at_bottom   out  1   o_pos_y == PADDLE_MAX
//   o_cmd_strobe  out  1   one-cycle pulse per accepted packet
// -----------------------------------------------------------------------------
module mouse_paddle_ctrl #(
  parameter int TICK_DIV   = 200000,
  parameter int STEP       = 4,
  parameter int PADDLE_MIN = 0,
  parameter int PADDLE_MAX = 400,
  parameter int INIT_POS   = 200,
  parameter int HOLD_TICKS = 30
) (
  input  logic       clk_12MHz,
  input  logic       reset,
  input  logic       i_upr,
  input  logic       i_downr,
  input  logic       i_valid,
  output logic [9:0] o_pos_y,
  output logic       o_move_up,
  output logic       o_move_down,
  output logic       o_at_top,
  output logic       o_at_bottom,
  output logic       o_cmd_strobe
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS);

  localparam logic [10:0] STEP_11 = 11'(STEP);
  localparam logic [10:0] MIN_11  = 11'(PADDLE_MIN);
  localparam logic [10:0] MAX_11  = 11'(PADDLE_MAX);
  localparam logic [9:0]  MIN_10  = 10'(PADDLE_MIN);
  localparam logic [9:0]  MAX_10  = 10'(PADDLE_MAX);
  localparam logic [9:0]  INIT_10 = 10'(INIT_POS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  // Synchroniser and valid-history registers
  logic              r_upr_meta;
  logic              r_upr_s;
  logic              r_downr_meta;
  logic              r_downr_s;
  logic              r_valid_meta;
  logic              r_valid_s;
  logic              r_valid_prev;
  logic [2:0]        r_fill;

  // Movement registers
  logic [TICK_W-1:0] r_tick_cnt;
  logic [HOLD_W-1:0] r_hold;
  state_t            r_state;
  logic [9:0]        r_pos_y;
  logic              r_move_up;
  logic              r_move_down;
  logic              r_cmd_strobe;

  // Combinational next-state terms
  logic              w_tick;
  logic              w_pkt;
  logic [10:0]       w_pos_ext;
  logic [9:0]        w_pos_dec;
  logic [10:0]       w_pos_inc_raw;
  logic [9:0]        w_pos_inc;
  logic [9:0]        w_pos_nxt;
  state_t            w_state_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [HOLD_W-1:0] w_hold_inc;

  // Two-flop synchronisers for the receiver levels, plus valid history.
  // r_fill marks how many history stages hold real samples since reset: the
  // history flops clear to 0, so without it a valid held high through reset
  // would look like a fresh rise once reset is released.
  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      r_upr_meta   <= 1'b0;
      r_upr_s      <= 1'b0;
      r_downr_meta <= 1'b0;
      r_downr_s    <= 1'b0;
      r_valid_meta <= 1'b0;
      r_valid_s    <= 1'b0;
      r_valid_prev <= 1'b0;
      r_fill       <= 3'b000;
    end else begin
      r_upr_meta   <= i_upr;
      r_upr_s      <= r_upr_meta;
      r_downr_meta <= i_downr;
      r_downr_s    <= r_downr_meta;
      r_valid_meta <= i_valid;
      r_valid_s    <= r_valid_meta;
      r_valid_prev <= r_valid_s;
      r_fill       <= {r_fill[1:0], 1'b1};
    end
  end

  assign w_pkt  = r_valid_s & ~r_valid_prev & r_fill[2];
  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Free-running movement tick divider; packets never restart it
  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= {TICK_W{1'b0}};
    end else if (w_tick) begin
      r_tick_cnt <= {TICK_W{1'b0}};
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  // Clamped step arithmetic, done 11 bits wide so it cannot wrap
  always_comb begin
    w_pos_ext     = {1'b0, r_pos_y};
    w_pos_inc_raw = w_pos_ext + STEP_11;
    if (w_pos_ext >= (MIN_11 + STEP_11)) begin
      w_pos_dec = 10'(w_pos_ext - STEP_11);
    end else begin
      w_pos_dec = MIN_10;
    end
    if (w_pos_inc_raw > MAX_11) begin
      w_pos_inc = MAX_10;
    end else begin
      w_pos_inc = w_pos_inc_raw[9:0];
    end
  end

  // Position update: moves on a tick according to the state before any packet
  always_comb begin
    w_pos_nxt = r_pos_y;
    if (w_tick) begin
      case (r_state)
        ST_UP:   w_pos_nxt = w_pos_dec;
        ST_DOWN: w_pos_nxt = w_pos_inc;
        default: w_pos_nxt = r_pos_y;
      endcase
    end else begin
      w_pos_nxt = r_pos_y;
    end
  end

  // Direction / hold-timeout decision; a packet overrides the tick's increment
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_hold_inc  = r_hold + HOLD_W'(1);
    if (w_pkt) begin
      w_hold_nxt = {HOLD_W{1'b0}};
      if (r_upr_s) begin
        w_state_nxt = ST_UP;
      end else if (r_downr_s) begin
        w_state_nxt = ST_DOWN;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else if (w_tick && (r_state != ST_IDLE)) begin
      if (w_hold_inc == HOLD_LAST) begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = {HOLD_W{1'b0}};
      end else begin
        w_state_nxt = r_state;
        w_hold_nxt  = w_hold_inc;
      end
    end else begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
    end
  end

  // FSM state, position and registered outputs
  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_hold       <= {HOLD_W{1'b0}};
      r_pos_y      <= INIT_10;
      r_move_up    <= 1'b0;
      r_move_down  <= 1'b0;
      r_cmd_strobe <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold       <= w_hold_nxt;
      r_pos_y      <= w_pos_nxt;
      r_move_up    <= (w_state_nxt == ST_UP);
      r_move_down  <= (w_state_nxt == ST_DOWN);
      r_cmd_strobe <= w_pkt;
    end
  end

  assign o_pos_y      = r_pos_y;
  assign o_move_up    = r_move_up;
  assign o_move_down  = r_move_down;
  assign o_cmd_strobe = r_cmd_strobe;
  // Limit flags follow pos_y directly so they are valid straight out of reset
  assign o_at_top     = (r_pos_y == MIN_10);
  assign o_at_bottom  = (r_pos_y == MAX_10);

endmodule

// File: doc/mouse_paddle_ctrl.md
Name: mouse_paddle_ctrl

Overview:
- Sits directly downstream of the PS/2 mouse receiver in the ball game.
- Takes the receiver's button-decode levels (upr = left button, downr = right button) and its packet-valid flag.
- Turns them into a rate-limited, clamped vertical paddle position for the video/ball logic.
- Inputs arrive from the receiver's filtered-PS/2-clock domain, so they are resynchronised to clk_12MHz.

Parameters:
- TICK_DIV, 200000, clk_12MHz cycles per movement tick (must be ≥2).
- STEP, 4, pixels moved per tick.
- PADDLE_MIN, 0, smallest legal pos_y (top).
- PADDLE_MAX, 400, largest legal pos_y (bottom).
- INIT_POS, 200, pos_y after reset.
- HOLD_TICKS, 30, ticks without a new packet before movement stops.

Ports:
- clk_12MHz  in  1  system clock
- reset  in  1  asynchronous, active-low
- upr  in  1  left-button level from receiver (async domain)
- downr  in  1  right-button level from receiver (async domain)
- valid  in  1  packet-valid level from receiver (async domain)
- pos_y  out  10  paddle top coordinate
- move_up  out  1  FSM in UP
- move_down  out  1  FSM in DOWN
- at_top  out  1  pos_y == PADDLE_MIN
- at_bottom  out  1  pos_y == PADDLE_MAX
- cmd_strobe  out  1  one-cycle pulse per accepted packet

Behaviour:
- Reset (async, active-low):
  - sync flops and valid history = 0; tick counter = 0; hold counter = 0; FSM = IDLE.
  - pos_y = INIT_POS; move_up = move_down = cmd_strobe = 0.
  - at_top/at_bottom reflect INIT_POS immediately (combinational compares on pos_y).
- Synchronisation:
  - upr, downr, valid each pass through 2 flops.
  - valid_s rising edge (valid_s = 1, previous = 0) = packet event; it is detected 3 clocks after the valid input rises.
- On a packet event:
  - cmd_strobe = 1 for exactly 1 cycle.
  - Hold counter cleared.
  - Next state from synced levels sampled in the same cycle: upr_s → UP (upr has priority if both are 1), else downr_s → DOWN, else IDLE.
- FSM states IDLE, UP, DOWN; move_up = (state == UP), move_down = (state == DOWN), both registered.
- Tick counter:
  - Free-runs 0..TICK_DIV-1 in every state; tick = 1 in the cycle the count is TICK_DIV-1, then it wraps to 0.
  - Not reset by packets, so first-move latency after a command is 1..TICK_DIV cycles.
- On tick:
  - UP: pos_y = max(pos_y − STEP, PADDLE_MIN).
  - DOWN: pos_y = min(pos_y + STEP, PADDLE_MAX).
  - Arithmetic is 11-bit, with no wrap below 0 or above 1023.
  - IDLE: pos_y unchanged.
- Hold timeout:
  - In UP/DOWN, each tick increments the hold counter.
  - When it reaches HOLD_TICKS, FSM → IDLE and the counter clears.
  - The move on the HOLD_TICKS-th tick still occurs.
  - Counter stays 0 in IDLE.
- Simultaneous events: if a packet event and a tick fall in the same cycle, the move uses the old state and the state update uses the packet. The packet's hold-counter clear wins over the increment.
- At a limit: the FSM stays in UP/DOWN and pos_y holds; at_top/at_bottom are asserted.
- valid held high: only one event; a new event requires valid to fall and rise again.
- Reset mid-move: immediate return to reset values; the first post-reset packet needs a fresh valid rise.

Test Plan (TICK_DIV=4, STEP=3, MIN=0, MAX=20, INIT=10, HOLD_TICKS=3):
- Reset release, no inputs → pos_y = 10, all flags 0, pos_y constant for 100 cycles.
- upr = 1, pulse valid → cmd_strobe once 3 cycles after the valid rise; pos_y 10 → 7 → 4 → 1; then IDLE, move_up = 0, pos_y stays 1.
- Repeated upr packets every 2 ticks → pos_y 7, 4, 1, 0, 0; at_top = 1 once pos_y = 0, no underflow.
- downr = 1 packets repeated → pos_y climbs by 3 to 19, then 20 and holds; at_bottom = 1.
- upr = downr = 1 with a valid pulse → move_up = 1, move_down = 0; a packet with both 0 → IDLE on the next cycle after the event.
- Assert reset mid-DOWN at pos_y = 16 → pos_y = 10 and FSM IDLE asynchronously. Holding valid high across the release gives no cmd_strobe until valid toggles.
